// File: rtl/sd_spi_arbiter.sv
// Two-requester SD-card SPI arbiter with a single mode-0 byte shift engine.
// Ownership is granted per transaction and held by the owner's chip-select.
module sd_spi_arbiter #(
  parameter bit         A_PRIORITY = 1'b1,
  parameter logic [7:0] IDLE_FILL  = 8'hFF
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ck_en_i,
  input  logic       sd_cd_i,
  input  logic       a_cs_n_i,
  input  logic       a_req_i,
  input  logic [7:0] a_wdata_i,
  output logic [7:0] a_rdata_o,
  output logic       a_busy_o,
  output logic       a_done_o,
  input  logic       b_cs_n_i,
  input  logic       b_req_i,
  input  logic [7:0] b_wdata_i,
  output logic [7:0] b_rdata_o,
  output logic       b_busy_o,
  output logic       b_done_o,
  output logic [1:0] owner_o,
  input  logic       sd_miso_i,
  output logic       sd_mosi_o,
  output logic       sd_sck_o,
  output logic       sd_cs_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       cur_q, cur_d;            // 0 = transfer belongs to A, 1 = B
  logic [7:0] sr_q, sr_d;
  logic       miso_q, miso_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       sck_q, sck_d;
  logic       cd_seen_q, cd_seen_d;
  logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [7:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic       a_done_q, a_done_d, b_done_q, b_done_d;
  logic       a_busy_q, a_busy_d, b_busy_q, b_busy_d;
  logic       sd_cs_q, sd_cs_d, mosi_q, mosi_d;

  logic       active_a, active_b, start_a, start_b, cand_a, cand_b;
  logic [7:0] rx_byte;

  // Next-state logic: pending flags, ownership, shift engine and registered outputs.
  always_comb begin
    active_a  = (state_q != ST_IDLE) && !cur_q;
    active_b  = (state_q != ST_IDLE) && cur_q;
    start_a   = (state_q == ST_IDLE) && (owner_q == OWN_A) && pend_a_q;
    start_b   = (state_q == ST_IDLE) && (owner_q == OWN_B) && pend_b_q;
    cand_a    = !a_cs_n_i || pend_a_q || a_req_i;
    cand_b    = !b_cs_n_i || pend_b_q || b_req_i;
    rx_byte   = {sr_q[6:0], miso_q};

    state_d   = state_q;
    cur_d     = cur_q;
    sr_d      = sr_q;
    miso_d    = miso_q;
    bitcnt_d  = bitcnt_q;
    sck_d     = sck_q;
    cd_seen_d = cd_seen_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;

    if (start_a) begin
      pend_a_d = 1'b0;
    end else if (a_req_i && !active_a) begin
      pend_a_d = 1'b1;
    end else begin
      pend_a_d = pend_a_q;
    end
    if (start_b) begin
      pend_b_d = 1'b0;
    end else if (b_req_i && !active_b) begin
      pend_b_d = 1'b1;
    end else begin
      pend_b_d = pend_b_q;
    end

    // A same-cycle req from the owner holds the link, so release also waits on req.
    if (state_q == ST_IDLE) begin
      case (owner_q)
        OWN_NONE: begin
          if (cand_a && (!cand_b || A_PRIORITY)) begin
            owner_d = OWN_A;
          end else if (cand_b) begin
            owner_d = OWN_B;
          end else begin
            owner_d = OWN_NONE;
          end
        end
        OWN_A: begin
          if (a_cs_n_i && !pend_a_q && !a_req_i) begin
            owner_d = OWN_NONE;
          end else begin
            owner_d = OWN_A;
          end
        end
        OWN_B: begin
          if (b_cs_n_i && !pend_b_q && !b_req_i) begin
            owner_d = OWN_NONE;
          end else begin
            owner_d = OWN_B;
          end
        end
        default: owner_d = OWN_NONE;
      endcase
    end else begin
      owner_d = owner_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_a || start_b) begin
          sr_d      = start_a ? a_wdata_i : b_wdata_i;
          cur_d     = !start_a;
          bitcnt_d  = 4'd0;
          sck_d     = 1'b0;
          cd_seen_d = sd_cd_i;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        cd_seen_d = cd_seen_q | sd_cd_i;
        if (ck_en_i) begin
          sck_d    = !sck_q;
          bitcnt_d = bitcnt_q + 4'd1;
          // Rising edge samples MISO; falling edge shifts so the next MSB drives MOSI.
          if (!sck_q) begin
            miso_d = sd_miso_i;
          end else begin
            sr_d = rx_byte;
          end
          if (bitcnt_q == 4'd15) begin
            state_d = ST_DONE;
            if (cur_q) begin
              b_rdata_d = (cd_seen_q || sd_cd_i) ? IDLE_FILL : rx_byte;
              b_done_d  = 1'b1;
            end else begin
              a_rdata_d = (cd_seen_q || sd_cd_i) ? IDLE_FILL : rx_byte;
              a_done_d  = 1'b1;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    a_busy_d = pend_a_d || ((state_d != ST_IDLE) && !cur_d);
    b_busy_d = pend_b_d || ((state_d != ST_IDLE) && cur_d);
    mosi_d   = (state_d == ST_SHIFT) ? sr_d[7] : 1'b1;
    if (sd_cd_i) begin
      sd_cs_d = 1'b1;
    end else if (owner_d == OWN_A) begin
      sd_cs_d = a_cs_n_i;
    end else if (owner_d == OWN_B) begin
      sd_cs_d = b_cs_n_i;
    end else begin
      sd_cs_d = 1'b1;
    end
  end

  // State and output registers; reset aborts any byte in flight.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      cur_q     <= 1'b0;
      sr_q      <= 8'hFF;
      miso_q    <= 1'b1;
      bitcnt_q  <= 4'd0;
      sck_q     <= 1'b0;
      cd_seen_q <= 1'b0;
      pend_a_q  <= 1'b0;
      pend_b_q  <= 1'b0;
      a_rdata_q <= 8'hFF;
      b_rdata_q <= 8'hFF;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_busy_q  <= 1'b0;
      b_busy_q  <= 1'b0;
      sd_cs_q   <= 1'b1;
      mosi_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cur_q     <= cur_d;
      sr_q      <= sr_d;
      miso_q    <= miso_d;
      bitcnt_q  <= bitcnt_d;
      sck_q     <= sck_d;
      cd_seen_q <= cd_seen_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_busy_q  <= a_busy_d;
      b_busy_q  <= b_busy_d;
      sd_cs_q   <= sd_cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign a_busy_o  = a_busy_q;
  assign a_done_o  = a_done_q;
  assign b_rdata_o = b_rdata_q;
  assign b_busy_o  = b_busy_q;
  assign b_done_o  = b_done_q;
  assign owner_o   = owner_q;
  assign sd_mosi_o = mosi_q;
  assign sd_sck_o  = sck_q;
  assign sd_cs_o   = sd_cs_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Scoreboard bench for sd_spi_arbiter: stimulus pushes expected bytes per
// requester, a monitor pops and compares on every done pulse.
module tb_sd_spi_arbiter;

  logic clk28, rst_n, ck_en, sd_cd;
  logic a_cs_n, a_req, b_cs_n, b_req;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic a_busy, a_done, b_busy, b_done;
  logic [1:0] owner;
  logic sd_miso, sd_mosi, sd_sck, sd_cs;

  logic [7:0] a_rdata2, b_rdata2;
  logic a_busy2, a_done2, b_busy2, b_done2;
  logic [1:0] owner2;
  logic sd_mosi2, sd_sck2, sd_cs2;

  typedef struct { logic [7:0] wdata; logic [7:0] rdata; } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];

  int vectors = 0;
  int miscompares = 0;
  int cs_hi_n, bbusy_lo_n, owner_b_n;

  logic [7:0] card_byte;
  logic [2:0] card_cnt;
  logic [7:0] mosi_cap;

  sd_spi_arbiter #(.A_PRIORITY(1'b1), .IDLE_FILL(8'hFF)) dut (
    .clk28(clk28), .rst_n(rst_n), .ck_en_i(ck_en), .sd_cd_i(sd_cd),
    .a_cs_n_i(a_cs_n), .a_req_i(a_req), .a_wdata_i(a_wdata), .a_rdata_o(a_rdata),
    .a_busy_o(a_busy), .a_done_o(a_done),
    .b_cs_n_i(b_cs_n), .b_req_i(b_req), .b_wdata_i(b_wdata), .b_rdata_o(b_rdata),
    .b_busy_o(b_busy), .b_done_o(b_done),
    .owner_o(owner), .sd_miso_i(sd_miso), .sd_mosi_o(sd_mosi), .sd_sck_o(sd_sck), .sd_cs_o(sd_cs)
  );

  sd_spi_arbiter #(.A_PRIORITY(1'b0), .IDLE_FILL(8'hFF)) dut_bpri (
    .clk28(clk28), .rst_n(rst_n), .ck_en_i(ck_en), .sd_cd_i(sd_cd),
    .a_cs_n_i(a_cs_n), .a_req_i(a_req), .a_wdata_i(a_wdata), .a_rdata_o(a_rdata2),
    .a_busy_o(a_busy2), .a_done_o(a_done2),
    .b_cs_n_i(b_cs_n), .b_req_i(b_req), .b_wdata_i(b_wdata), .b_rdata_o(b_rdata2),
    .b_busy_o(b_busy2), .b_done_o(b_done2),
    .owner_o(owner2), .sd_miso_i(sd_miso), .sd_mosi_o(sd_mosi2), .sd_sck_o(sd_sck2), .sd_cs_o(sd_cs2)
  );

  initial begin
    clk28 = 1'b0;
    forever #5 clk28 = ~clk28;
  end

  initial begin
    ck_en = 1'b0;
    forever begin
      @(negedge clk28);
      ck_en = ~ck_en;
    end
  end

  // Card model: MSB first, advances one bit per SCK rising edge while selected.
  always @(posedge sd_sck or posedge sd_cs) begin
    if (sd_cs) card_cnt <= 3'd0;
    else       card_cnt <= card_cnt + 3'd1;
  end
  assign sd_miso = card_byte[3'd7 - card_cnt];

  always @(posedge sd_sck) mosi_cap <= {mosi_cap[6:0], sd_mosi};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input bit port, input logic [7:0] rdata);
    exp_t e;
    if (port ? (sb_b.size() == 0) : (sb_a.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_done port=%0d: got rdata %h, expected no done", port, rdata);
    end else begin
      e = port ? sb_b.pop_front() : sb_a.pop_front();
      chk(port ? "b_rdata" : "a_rdata", rdata, e.rdata);
      chk(port ? "b_mosi_byte" : "a_mosi_byte", mosi_cap, e.wdata);
    end
  endtask

  // Monitor: every done pulse is checked against the oldest expectation of that port.
  always @(negedge clk28) begin
    if (rst_n && a_done) sb_pop(1'b0, a_rdata);
    if (rst_n && b_done) sb_pop(1'b1, b_rdata);
  end

  task automatic pulse(input bit port, input logic [7:0] wd, input logic [7:0] card,
                       input logic [7:0] exp, input bit track);
    exp_t e;
    e.wdata = wd;
    e.rdata = exp;
    card_byte = card;
    if (port) begin b_wdata = wd; b_req = 1'b1; if (track) sb_b.push_back(e); end
    else      begin a_wdata = wd; a_req = 1'b1; if (track) sb_a.push_back(e); end
    @(negedge clk28);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic wait_done(input bit port);
    int n = 0;
    @(negedge clk28);
    while (!(port ? b_done : a_done) && n < 200) begin
      if (sd_cs) cs_hi_n++;
      if (!b_busy) bbusy_lo_n++;
      if (owner == 2'b10) owner_b_n++;
      n++;
      @(negedge clk28);
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout port=%0d: got no done, expected done within 200 cycles", port);
    end
  endtask

  task automatic wait_owner(input logic [1:0] want, input int bound, input string name);
    int n = 0;
    while (owner !== want && n < bound) begin
      n++;
      @(negedge clk28);
    end
    chk(name, 8'(owner), 8'(want));
  endtask

  task automatic wait_card_bit(input logic [2:0] k);
    int n = 0;
    while (card_cnt != k && n < 100) begin
      n++;
      @(negedge clk28);
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL bit_timeout: got bit %0d, expected bit %0d", card_cnt, k);
    end
  endtask

  initial begin
    rst_n = 1'b0; sd_cd = 1'b0;
    a_cs_n = 1'b1; a_req = 1'b0; a_wdata = 8'h00;
    b_cs_n = 1'b1; b_req = 1'b0; b_wdata = 8'h00;
    card_byte = 8'hFF;
    repeat (3) @(negedge clk28);
    chk("rst_owner", 8'(owner), 8'h00);
    chk("rst_sd_cs", 8'(sd_cs), 8'h01);
    chk("rst_sck", 8'(sd_sck), 8'h00);
    chk("rst_mosi", 8'(sd_mosi), 8'h01);
    chk("rst_a_rdata", a_rdata, 8'hFF);
    chk("rst_b_rdata", b_rdata, 8'hFF);
    chk("rst_busy", {6'd0, a_busy, b_busy}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk28);

    // Single A byte: 0x40 out, card returns 0xA5.
    a_cs_n = 1'b0;
    pulse(1'b0, 8'h40, 8'hA5, 8'hA5, 1'b1);
    chk("t1_owner", 8'(owner), 8'h01);
    chk("t1_sd_cs", 8'(sd_cs), 8'h00);
    chk("t1_a_busy", 8'(a_busy), 8'h01);
    wait_done(1'b0);
    chk("t1_b_rdata", b_rdata, 8'hFF);
    chk("t1_b_busy", 8'(b_busy), 8'h00);
    @(negedge clk28);

    // A holds the link for three bytes while B waits.
    cs_hi_n = 0; bbusy_lo_n = 0; owner_b_n = 0;
    pulse(1'b0, 8'h51, 8'h3C, 8'h3C, 1'b1);
    b_cs_n = 1'b0;
    pulse(1'b1, 8'hB7, 8'h3C, 8'h3C, 1'b1);
    wait_done(1'b0);
    @(negedge clk28);
    pulse(1'b0, 8'h52, 8'h3C, 8'h3C, 1'b1);
    wait_done(1'b0);
    @(negedge clk28);
    pulse(1'b0, 8'h53, 8'h3C, 8'h3C, 1'b1);
    wait_done(1'b0);
    chk("t2_cs_glitch", 8'(cs_hi_n), 8'h00);
    chk("t2_b_busy_low", 8'(bbusy_lo_n), 8'h00);
    chk("t2_b_early", 8'(owner_b_n), 8'h00);
    a_cs_n = 1'b1;
    wait_owner(2'b10, 8, "t2_b_granted");
    wait_done(1'b1);
    b_cs_n = 1'b1;
    wait_owner(2'b00, 8, "t2_release");

    // Simultaneous acquisition: A wins in dut, B wins in dut_bpri.
    card_byte = 8'h96;
    a_cs_n = 1'b0; b_cs_n = 1'b0;
    a_wdata = 8'h0F; b_wdata = 8'hF0;
    sb_a.push_back('{8'h0F, 8'h96});
    sb_b.push_back('{8'hF0, 8'h96});
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk28);
    a_req = 1'b0; b_req = 1'b0;
    chk("t3_owner_apri", 8'(owner), 8'h01);
    chk("t3_owner_bpri", 8'(owner2), 8'h02);
    wait_done(1'b0);
    a_cs_n = 1'b1;
    wait_done(1'b1);
    b_cs_n = 1'b1;
    wait_owner(2'b00, 8, "t3_release");

    // A raises cs_n mid-byte: byte still completes, then release.
    a_cs_n = 1'b0;
    pulse(1'b0, 8'hC3, 8'h00, 8'h00, 1'b1);
    wait_card_bit(3'd3);
    a_cs_n = 1'b1;
    wait_done(1'b0);
    @(negedge clk28);
    wait_owner(2'b00, 2, "t4_release");
    chk("t4_a_busy", 8'(a_busy), 8'h00);

    // Card removed mid-byte: chip-select drops and the byte returns fill.
    a_cs_n = 1'b0;
    pulse(1'b0, 8'h77, 8'h33, 8'hFF, 1'b1);
    wait_card_bit(3'd4);
    sd_cd = 1'b1;
    @(negedge clk28);
    chk("t5_sd_cs", 8'(sd_cs), 8'h01);
    wait_done(1'b0);
    sd_cd = 1'b0;
    a_cs_n = 1'b1;
    wait_owner(2'b00, 8, "t5_release");

    // Reset in the middle of a B byte: no done, then A works normally.
    b_cs_n = 1'b0;
    pulse(1'b1, 8'hE1, 8'h0F, 8'h0F, 1'b0);
    wait_card_bit(3'd5);
    rst_n = 1'b0;
    b_cs_n = 1'b1;
    #1;
    chk("t6_owner", 8'(owner), 8'h00);
    chk("t6_sd_cs", 8'(sd_cs), 8'h01);
    chk("t6_sck", 8'(sd_sck), 8'h00);
    chk("t6_mosi", 8'(sd_mosi), 8'h01);
    chk("t6_b_busy", 8'(b_busy), 8'h00);
    chk("t6_b_rdata", b_rdata, 8'hFF);
    repeat (3) begin
      @(negedge clk28);
      chk("t6_b_done", 8'(b_done), 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk28);
    a_cs_n = 1'b0;
    pulse(1'b0, 8'h9A, 8'hC6, 8'hC6, 1'b1);
    wait_done(1'b0);
    a_cs_n = 1'b1;
    wait_owner(2'b00, 8, "t6_release");

    repeat (4) @(negedge clk28);
    chk("sb_a_empty", 8'(sb_a.size()), 8'h00);
    chk("sb_b_empty", 8'(sb_b.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_spi_arbiter.md
Name: sd_spi_arbiter

Overview:
Shares the single SD-card SPI link between two byte-transfer requesters: the CPU-side DivMMC port path (requester A) and the hardware boot/sector loader (requester B). Contains the only SPI shift engine driving sd_sck/sd_mosi/sd_cs. Ownership is granted per transaction and locked by the owner's chip-select, so command/response sequences from one requester never interleave with the other's.

Parameters:
A_PRIORITY, 1, 1 = requester A wins simultaneous acquisition from no-owner; 0 = B wins.
IDLE_FILL, 8'hFF, rdata returned for every transfer while the card is absent (sd_cd=1).

Ports:
clk28  in  1  system clock
rst_n  in  1  async active-low reset
ck_en  in  1  SPI bit-phase strobe, one clk28 cycle wide (ck14 rate)
sd_cd  in  1  card-detect, 1 = card absent
a_cs_n  in  1  requester A chip-select request, active low
a_req  in  1  requester A byte-transfer request, 1-cycle pulse
a_wdata  in  8  requester A byte to send
a_rdata  out  8  requester A last received byte
a_busy  out  1  A transfer pending or in progress
a_done  out  1  A transfer complete, 1-cycle pulse
b_cs_n, b_req, b_wdata, b_rdata, b_busy, b_done  (same as A, for requester B)
owner  out  2  00 none, 01 A, 10 B
sd_miso  in  1  card data out
sd_mosi  out  1  card data in
sd_sck  out  1  SPI clock, mode 0
sd_cs  out  1  card select, active low

Behaviour:
- Reset: owner=00, engine IDLE, sd_cs=1, sd_sck=0, sd_mosi=1, a/b_rdata=8'hFF, busy=0, done=0, pending flags cleared. Reset mid-transfer aborts immediately; no done pulse.
- Pending: x_req sets pend_x (x_busy=1 the next cycle). A second x_req while pend_x=1 or x's transfer is active is ignored. pend_x clears when its transfer starts. x_busy = pend_x | (engine active for x).
- Acquisition, evaluated only when owner=00 and engine IDLE: a requester is a candidate if x_cs_n=0 or pend_x=1. If both are candidates, A_PRIORITY decides. owner updates on the next clk28.
- Release: when owner=x, x_cs_n=1, pend_x=0 and engine IDLE, owner returns to 00 on the next cycle. Raising cs_n mid-byte does not abort; the byte completes, then release follows.
- Non-owner: cs_n has no effect on sd_cs. req stays pending (busy=1) until that requester owns the link.
- sd_cs = owner's cs_n when owner≠00 and sd_cd=0; otherwise 1.
- Engine FSM:
  - IDLE: if owner=x and pend_x, load shift register with x_wdata, clear pend_x, set bitcnt=0, go SHIFT.
  - SHIFT: on each ck_en, toggle sck. On the rising edge, sample sd_miso into the LSB. On the falling edge, shift left and present the next MSB on mosi. After 16 ck_en strobes (8 bits), sck=0; go DONE.
  - DONE: one clk28 cycle. x_rdata = shifted byte, or IDLE_FILL if sd_cd=1 at any point during the byte. x_done=1. Return to IDLE.
- sd_mosi: MSB of the shift register during SHIFT; 1 otherwise.
- Latency: req to transfer start is at most 2 clk28 cycles when owner=00 or already x. Byte time is 16 ck_en strobes plus 1 cycle.
- Simultaneous: x_req in the same cycle as a release of owner=x keeps ownership (pend_x blocks release). Card removal mid-byte: sd_cs goes high at once, the byte completes with IDLE_FILL, and ownership follows the normal rules.
- Owner never changes while the engine is non-IDLE.

Test Plan:
- Reset, then A: cs_n=0 and req with wdata=8'h40, card returning 8'hA5 → owner=01, sd_cs=0, mosi bits 0,1,0,0,0,0,0,0, a_done after 16 ck_en plus 1, a_rdata=8'hA5, b untouched.
- A holds cs_n=0 across 3 bytes while B pulses req → b_busy=1 throughout. B is granted only after A raises cs_n. sd_cs never glitches high between A's bytes; B's byte follows.
- A and B assert cs_n and req in the same cycle with A_PRIORITY=1 → owner=01 first. With A_PRIORITY=0 → owner=10 first.
- A raises cs_n at bit 3 of a byte → byte completes, a_done pulses, owner=00 one cycle after DONE.
- sd_cd=1 set mid-byte → sd_cs=1 the next cycle, done pulses on schedule, rdata=8'hFF.
- Assert rst_n=0 at bit 5 of a B byte → all outputs at reset values, no b_done. A request after reset completes normally.
